bitwise_logic_unit: RTL and testbench
=====================================

# bitwise_logic_unit

Parametrised, registered successor to the 4-bit combinational AND in the Logical group. It computes one of eight bitwise functions on two WIDTH-bit operands, including an accumulating AND that keeps a running mask across transactions. Results go through a one-deep output register with valid/ready flow control and status flags, so the block can sit in the ALU result path behind the operand select and ahead of the result mux.

## Interface
- WIDTH, 4, operand/result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept this cycle
- op  input  3  function select (see Operation)
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B (ignored for op 6, 7)
- acc_clr  input  1  reset accumulator to all-ones (independent of in_valid)
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  downstream consumes result
- result  output  WIDTH  registered result
- flag_zero  output  1  result == 0
- flag_ones  output  1  result == all ones
- flag_par  output  1  XOR-reduction of result
- acc  output  WIDTH  current accumulator value

## Operation
- Ops: 0 AND x&y; 1 OR x|y; 2 XOR x^y; 3 NAND ~(x&y); 4 NOR ~(x|y); 5 XNOR ~(x^y); 6 NOT ~x; 7 ACC acc&x.
- Accept: a transfer occurs when in_valid && in_ready. Only an accepted op changes result/flags/acc.
- in_ready = !out_valid || out_ready (combinational; pass-through when consumer is ready).
- Output register: on accept, result <= f(op), flags computed from that same value, out_valid <= 1. Else if out_ready, out_valid <= 0. result/flags hold their value when not overwritten.
- Accumulator: reset value all-ones. On accepted op 7, acc <= acc_eff & x, where acc_eff = all-ones if acc_clr else acc, and result = acc_eff & x. acc_clr without an accepted op 7: acc <= all-ones. Non-ACC ops never touch acc.
- Flags are registered with result and are defined only while out_valid = 1; the bench checks them only then.
- Width rule: all ops are bitwise over WIDTH bits with no carries. flag_ones compares against {WIDTH{1'b1}}.

## Timing
- Latency 1: an op accepted at edge N is visible on result with out_valid = 1 after edge N.
- Throughput 1 op/cycle while out_ready = 1.
- Backpressure: out_valid = 1 and out_ready = 0 → in_ready = 0. result, flags and acc hold, and input is ignored.
- Simultaneous consume and accept (out_valid = 1, out_ready = 1, in_valid = 1): the new result replaces the old in the same edge and out_valid stays 1. Nothing is lost or duplicated.
- Reset (any cycle, including mid-stream with a pending result): after the edge, out_valid = 0, result = 0, flag_zero = 1, flag_ones = 0, flag_par = 0, acc = all-ones. in_ready = 1 in the first cycle after reset. Inputs are ignored in the cycle rst is high.
- rst has priority over acc_clr and over any transfer.

## Test plan
- Op sweep, WIDTH=4, out_ready=1: x=1100, y=1010 for ops 0–6 → results 1000, 1110, 0110, 0111, 0001, 1001, 0011, each one cycle after accept. Flags checked on each, e.g. XOR gives zero=0, ones=0, par=0.
- Accumulate: after reset, ACC with x=1110 then 0111 then 1011 → results 1110, 0110, 0010 and acc ends at 0010. Then acc_clr with ACC x=0101 in the same cycle → result 0101, acc=0101.
- Backpressure: accept AND 1111&0011, hold out_ready=0 for 3 cycles while in_valid=1 with x=0000 → result stays 0011, in_ready=0, acc unchanged. Release → result 0011 consumed, then the next op is accepted.
- Back-to-back with out_ready=1: ops on 4 consecutive cycles → 4 consecutive results, out_valid continuously 1, none dropped.
- Reset mid-operation: pending result 1111 (flag_ones=1) and acc=0010, assert rst one cycle → out_valid=0, result=0000, flag_zero=1, acc=1111. The next ACC x=1001 gives 1001.
- WIDTH=8 instance: NOR of 0x0F and 0xF0 → 0x00 with flag_zero=1. NOT of 0x00 → 0xFF with flag_ones=1, par=0.

Source files
------------

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_logic_unit
// Purpose  : Registered bitwise logic unit. It computes one of eight bitwise
//            functions on two WIDTH-bit operands. One of these is an
//            accumulating AND that keeps a running mask across transactions.
//            The result goes into a one-deep output register that uses
//            valid/ready handshaking. Zero, all-ones and parity flags are
//            registered together with the result.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - operand handshake (in_ready is combinational)
//            op, x, y            - function select and operands
//            acc_clr             - restore accumulator to all-ones
//            out_valid/out_ready - result handshake
//            result, flag_*      - registered result and status flags
//            acc                 - current accumulator value
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_logic_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_par,
    output logic [WIDTH-1:0] acc
);

    localparam logic [WIDTH-1:0] C_ONES   = {WIDTH{1'b1}};
    localparam logic [2:0]       C_OP_ACC = 3'd7;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ones_q;
    logic             par_q;
    logic [WIDTH-1:0] acc_q;

    logic             accept_w;
    logic [WIDTH-1:0] acc_eff_w;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] acc_d;

    // The slot frees up in the same cycle the consumer drains it.
    assign in_ready  = !valid_q || out_ready;
    assign accept_w  = in_valid && in_ready;

    // When acc_clr arrives together with an ACC op, the new mask is used.
    assign acc_eff_w = acc_clr ? C_ONES : acc_q;

    always_comb begin
        result_d = '0;
        case (op)
            3'd0:    result_d = x & y;
            3'd1:    result_d = x | y;
            3'd2:    result_d = x ^ y;
            3'd3:    result_d = ~(x & y);
            3'd4:    result_d = ~(x | y);
            3'd5:    result_d = ~(x ^ y);
            3'd6:    result_d = ~x;
            default: result_d = acc_eff_w & x;
        endcase
    end

    // A clear without an accepted ACC op still restores all-ones.
    always_comb begin
        acc_d = acc_q;
        if (accept_w && (op == C_OP_ACC)) begin
            acc_d = acc_eff_w & x;
        end else if (acc_clr) begin
            acc_d = C_ONES;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ones_q   <= 1'b0;
            par_q    <= 1'b0;
            acc_q    <= C_ONES;
        end else begin
            acc_q <= acc_d;
            if (accept_w) begin
                valid_q  <= 1'b1;
                result_q <= result_d;
                zero_q   <= (result_d == '0);
                ones_q   <= (result_d == C_ONES);
                par_q    <= ^result_d;
            end else if (out_ready) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign flag_zero = zero_q;
    assign flag_ones = ones_q;
    assign flag_par  = par_q;
    assign acc       = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_logic_unit
// Purpose  : Self-checking bench for bitwise_logic_unit. It covers WIDTH=4
//            vectors, hand-written multi-cycle sequences, randomized traffic
//            compared against a reference model, and a WIDTH=8 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_unit;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       in_valid, out_ready, acc_clr;
    logic [2:0] op;
    logic [3:0] x, y;
    logic       in_ready, out_valid, flag_zero, flag_ones, flag_par;
    logic [3:0] result, acc;

    bitwise_logic_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x(x), .y(y), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flag_zero(flag_zero),
        .flag_ones(flag_ones), .flag_par(flag_par), .acc(acc)
    );

    // WIDTH=8 instance
    logic       in_valid8, out_ready8, acc_clr8;
    logic [2:0] op8;
    logic [7:0] x8, y8;
    logic       in_ready8, out_valid8, flag_zero8, flag_ones8, flag_par8;
    logic [7:0] result8, acc8;

    bitwise_logic_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .x(x8), .y(y8), .acc_clr(acc_clr8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .flag_zero(flag_zero8),
        .flag_ones(flag_ones8), .flag_par(flag_par8), .acc(acc8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: each op written as an arithmetic truth rule over a 4-bit mask.
    function automatic logic [3:0] ref_f(input logic [2:0] o, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] m);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            case (o)
                3'd0: r[i] = a[i] && b[i];
                3'd1: r[i] = a[i] || b[i];
                3'd2: r[i] = a[i] != b[i];
                3'd3: r[i] = !(a[i] && b[i]);
                3'd4: r[i] = !(a[i] || b[i]);
                3'd5: r[i] = a[i] == b[i];
                3'd6: r[i] = !a[i];
                default: r[i] = m[i] && a[i];
            endcase
        end
        return r;
    endfunction

    function automatic int popcount4(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk_flags(input string tag, input logic [3:0] r);
        chk({tag, ".zero"}, 32'(flag_zero), 32'(r == 4'd0));
        chk({tag, ".ones"}, 32'(flag_ones), 32'(r == 4'd15));
        chk({tag, ".par"},  32'(flag_par),  32'(popcount4(r) % 2));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic       clr;
        logic [3:0] res;
        logic [3:0] acc;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic       m_valid;
        logic [3:0] m_res, m_acc, m_eff, f;
        logic       m_rdy;

        tbl[0]  = '{3'd0, 4'b1100, 4'b1010, 1'b0, 4'b1000, 4'b1111};
        tbl[1]  = '{3'd1, 4'b1100, 4'b1010, 1'b0, 4'b1110, 4'b1111};
        tbl[2]  = '{3'd2, 4'b1100, 4'b1010, 1'b0, 4'b0110, 4'b1111};
        tbl[3]  = '{3'd3, 4'b1100, 4'b1010, 1'b0, 4'b0111, 4'b1111};
        tbl[4]  = '{3'd4, 4'b1100, 4'b1010, 1'b0, 4'b0001, 4'b1111};
        tbl[5]  = '{3'd5, 4'b1100, 4'b1010, 1'b0, 4'b1001, 4'b1111};
        tbl[6]  = '{3'd6, 4'b1100, 4'b1010, 1'b0, 4'b0011, 4'b1111};
        tbl[7]  = '{3'd7, 4'b1110, 4'b0000, 1'b0, 4'b1110, 4'b1110};
        tbl[8]  = '{3'd7, 4'b0111, 4'b0000, 1'b0, 4'b0110, 4'b0110};
        tbl[9]  = '{3'd7, 4'b1011, 4'b0000, 1'b0, 4'b0010, 4'b0010};
        tbl[10] = '{3'd7, 4'b0101, 4'b0000, 1'b1, 4'b0101, 4'b0101};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0; op = 3'd0; x = '0; y = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; acc_clr8 = 1'b0; op8 = 3'd0; x8 = '0; y8 = '0;
        tick; tick;
        rst = 1'b0;

        // Reset state
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result",    32'(result),    32'd0);
        chk("rst.flag_zero", 32'(flag_zero), 32'd1);
        chk("rst.flag_ones", 32'(flag_ones), 32'd0);
        chk("rst.flag_par",  32'(flag_par),  32'd0);
        chk("rst.acc",       32'(acc),       32'hF);
        chk("rst.in_ready",  32'(in_ready),  32'd1);

        // Op sweep and accumulation, back to back with out_ready=1
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; op = tbl[i].op; x = tbl[i].x; y = tbl[i].y; acc_clr = tbl[i].clr;
            tick;
            chk($sformatf("vec%0d.valid", i),  32'(out_valid), 32'd1);
            chk($sformatf("vec%0d.result", i), 32'(result),    32'(tbl[i].res));
            chk($sformatf("vec%0d.acc", i),    32'(acc),       32'(tbl[i].acc));
            chk_flags($sformatf("vec%0d", i), tbl[i].res);
        end
        acc_clr = 1'b0;

        // Backpressure
        op = 3'd0; x = 4'b1111; y = 4'b0011; in_valid = 1'b1;
        tick;
        chk("bp.first", 32'(result), 32'h3);
        out_ready = 1'b0; x = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
            tick;
            chk($sformatf("bp%0d.result", i), 32'(result),    32'h3);
            chk($sformatf("bp%0d.valid", i),  32'(out_valid), 32'd1);
            chk($sformatf("bp%0d.acc", i),    32'(acc),       32'h5);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        chk("bp.release.in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("bp.drained", 32'(out_valid), 32'd0);
        in_valid = 1'b1; op = 3'd1; x = 4'b0001; y = 4'b0100;
        tick;
        chk("bp.next.result", 32'(result),    32'h5);
        chk("bp.next.valid",  32'(out_valid), 32'd1);

        // Reset mid-operation with a pending all-ones result and acc=0010
        op = 3'd7; x = 4'b0010; acc_clr = 1'b1;
        tick;
        acc_clr = 1'b0; op = 3'd1; x = 4'b1111; y = 4'b0000;
        tick;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("rm.pend.result", 32'(result),    32'hF);
        chk("rm.pend.ones",   32'(flag_ones), 32'd1);
        chk("rm.pend.acc",    32'(acc),       32'h2);
        rst = 1'b1; in_valid = 1'b1; op = 3'd0; acc_clr = 1'b1;
        tick;
        rst = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        chk("rm.valid",    32'(out_valid), 32'd0);
        chk("rm.result",   32'(result),    32'd0);
        chk("rm.zero",     32'(flag_zero), 32'd1);
        chk("rm.ones",     32'(flag_ones), 32'd0);
        chk("rm.acc",      32'(acc),       32'hF);
        #1;
        chk("rm.in_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b1; op = 3'd7; x = 4'b1001;
        tick;
        chk("rm.acc_op.result", 32'(result), 32'h9);
        chk("rm.acc_op.acc",    32'(acc),    32'h9);
        in_valid = 1'b0;
        tick;

        // Randomized traffic against the reference model
        m_valid = 1'b0; m_res = result; m_acc = acc;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            acc_clr   = ($urandom_range(0, 9) == 0);
            op = 3'($urandom_range(0, 7));
            x  = 4'($urandom);
            y  = 4'($urandom);
            #1;
            m_rdy = !m_valid || out_ready;
            chk("rnd.in_ready", 32'(in_ready), 32'(m_rdy));
            m_eff = acc_clr ? 4'hF : m_acc;
            f = ref_f(op, x, y, m_eff);
            if (in_valid && m_rdy) begin
                m_valid = 1'b1;
                m_res = f;
                if (op == 3'd7) m_acc = f;
                else if (acc_clr) m_acc = 4'hF;
            end else begin
                if (acc_clr) m_acc = 4'hF;
                if (out_ready) m_valid = 1'b0;
            end
            tick;
            chk("rnd.valid", 32'(out_valid), 32'(m_valid));
            chk("rnd.acc",   32'(acc),       32'(m_acc));
            if (m_valid) begin
                chk("rnd.result", 32'(result), 32'(m_res));
                chk_flags("rnd", m_res);
            end
        end
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        // WIDTH=8 boundary cases
        in_valid8 = 1'b1; op8 = 3'd4; x8 = 8'h0F; y8 = 8'hF0;
        tick;
        chk("w8.nor.result", 32'(result8),    32'h00);
        chk("w8.nor.zero",   32'(flag_zero8), 32'd1);
        chk("w8.nor.ones",   32'(flag_ones8), 32'd0);
        op8 = 3'd6; x8 = 8'h00;
        tick;
        chk("w8.not.result", 32'(result8),    32'hFF);
        chk("w8.not.ones",   32'(flag_ones8), 32'd1);
        chk("w8.not.par",    32'(flag_par8),  32'd0);
        chk("w8.not.zero",   32'(flag_zero8), 32'd0);
        op8 = 3'd7; x8 = 8'hA5;
        tick;
        chk("w8.acc.result", 32'(result8), 32'hA5);
        chk("w8.acc.acc",    32'(acc8),    32'hA5);
        chk("w8.acc.par",    32'(flag_par8), 32'd0);
        in_valid8 = 1'b0;
        tick;
        chk("w8.drain", 32'(out_valid8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
